// File: rtl/neuron_pkg.sv
// ============================================================================
// neuron_pkg : shared constants, data type and state encoding for the
//              activation/division stage.  Rev 1.0
// ============================================================================
`default_nettype none

package neuron_pkg;

   localparam int N_WIDTH = 15;
   localparam int N_FRAC  = 12;
   localparam int FIX_ONE = 1 << N_FRAC;

   typedef logic signed [N_WIDTH:0] fix_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DIV  = 2'd1,
      ST_FIN  = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/frac_divider.sv
// ============================================================================
// frac_divider : unsigned radix-2 restoring fractional divider, one quotient
//                bit per step.  Rev 1.0
// ============================================================================
`default_nettype none

module frac_divider
   import neuron_pkg::*;
#(
   parameter int WIDTH = N_WIDTH,
   parameter int FRAC  = N_FRAC
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic             step_i,
   input  logic [WIDTH+1:0] r_init_i,
   input  logic [WIDTH:0]   d_i,
   output logic [FRAC-1:0]  q_o,
   output logic             last_o
);

   localparam int CNT_W = $clog2(FRAC + 1);

   logic [WIDTH+1:0] r_q, r_d, w_r2, w_dext;
   logic [WIDTH:0]   d_q, d_d;
   logic [FRAC-1:0]  q_q, q_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // r < d < 2^15 always holds, so the shift cannot lose a set bit
   assign w_r2   = r_q << 1;
   assign w_dext = {1'b0, d_q};

   always_comb begin
      r_d   = r_q;
      d_d   = d_q;
      q_d   = q_q;
      cnt_d = cnt_q;
      if (load_i) begin
         r_d   = r_init_i;
         d_d   = d_i;
         q_d   = '0;
         cnt_d = '0;
      end else if (step_i) begin
         if (w_r2 >= w_dext) begin
            r_d = w_r2 - w_dext;
            q_d = {q_q[FRAC-2:0], 1'b1};
         end else begin
            r_d = w_r2;
            q_d = {q_q[FRAC-2:0], 1'b0};
         end
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_q   <= '0;
         d_q   <= '0;
         q_q   <= '0;
         cnt_q <= '0;
      end else begin
         r_q   <= r_d;
         d_q   <= d_d;
         q_q   <= q_d;
         cnt_q <= cnt_d;
      end
   end

   assign q_o    = q_q;
   assign last_o = (cnt_q == CNT_W'(FRAC - 1));

endmodule

`default_nettype wire

// File: rtl/neuron_activation_div.sv
// ============================================================================
// neuron_activation_div : tanh = sinh/cosh via sequential division, or
//                         linear bypass, with saturation and overrun flags.
//                         Rev 1.0
// ============================================================================
`default_nettype none

module neuron_activation_div
   import neuron_pkg::*;
#(
   parameter int WIDTH = N_WIDTH,
   parameter int FRAC  = N_FRAC
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   input  logic               af_en,
   input  logic signed [WIDTH:0] sinh_in,
   input  logic signed [WIDTH:0] cosh_in,
   input  logic signed [WIDTH:0] lin_in,
   output logic signed [WIDTH:0] act_out,
   output logic               out_valid,
   output logic               busy,
   output logic               sat,
   output logic               overrun
);

   localparam logic signed [WIDTH:0] c_POS_ONE = (WIDTH+1)'(FIX_ONE);
   localparam logic signed [WIDTH:0] c_NEG_ONE = -c_POS_ONE;
   localparam logic signed [WIDTH:0] c_MIN     = {1'b1, {WIDTH{1'b0}}};
   localparam logic        [WIDTH:0] c_MAX_U   = {1'b0, {WIDTH{1'b1}}};

   state_t                  state_q, state_d;
   logic signed [WIDTH:0]   act_q, act_d;
   logic                    out_valid_q, out_valid_d;
   logic                    sat_q, sat_d;
   logic                    overrun_q, overrun_d;
   logic                    sign_q, sign_d;
   logic                    w_load, w_step, w_last;
   logic [FRAC-1:0]         w_q;
   logic [WIDTH:0]          w_abs;
   logic signed [WIDTH:0]   w_qext;

   // most-negative input has no positive twin; clip so it saturates
   assign w_abs  = (sinh_in == c_MIN) ? c_MAX_U
                 : (sinh_in[WIDTH] ? $unsigned(-sinh_in) : $unsigned(sinh_in));
   assign w_qext = $signed({{(WIDTH+1-FRAC){1'b0}}, w_q});

   frac_divider #(.WIDTH(WIDTH), .FRAC(FRAC)) u_div (
      .clk      (clk),
      .reset    (reset),
      .load_i   (w_load),
      .step_i   (w_step),
      .r_init_i ({1'b0, w_abs}),
      .d_i      ($unsigned(cosh_in)),
      .q_o      (w_q),
      .last_o   (w_last)
   );

   always_comb begin
      state_d     = state_q;
      act_d       = act_q;
      sat_d       = sat_q;
      sign_d      = sign_q;
      out_valid_d = 1'b0;
      overrun_d   = 1'b0;
      w_load      = 1'b0;
      w_step      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               if (!af_en) begin
                  act_d       = lin_in;
                  sat_d       = 1'b0;
                  out_valid_d = 1'b1;
               end else if (cosh_in <= 0 || w_abs >= $unsigned(cosh_in)) begin
                  act_d       = sinh_in[WIDTH] ? c_NEG_ONE : c_POS_ONE;
                  sat_d       = 1'b1;
                  out_valid_d = 1'b1;
               end else begin
                  w_load  = 1'b1;
                  sign_d  = sinh_in[WIDTH];
                  state_d = ST_DIV;
               end
            end
         end
         ST_DIV: begin
            overrun_d = in_valid;
            w_step    = 1'b1;
            if (w_last) state_d = ST_FIN;
         end
         ST_FIN: begin
            overrun_d   = in_valid;
            act_d       = sign_q ? -w_qext : w_qext;
            sat_d       = 1'b0;
            out_valid_d = 1'b1;
            state_d     = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         act_q       <= '0;
         out_valid_q <= 1'b0;
         sat_q       <= 1'b0;
         overrun_q   <= 1'b0;
         sign_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         act_q       <= act_d;
         out_valid_q <= out_valid_d;
         sat_q       <= sat_d;
         overrun_q   <= overrun_d;
         sign_q      <= sign_d;
      end
   end

   assign act_out   = act_q;
   assign out_valid = out_valid_q;
   assign sat       = sat_q;
   assign overrun   = overrun_q;
   assign busy      = (state_q != ST_IDLE);

endmodule

`default_nettype wire
